// File: rtl/cache_set_assoc.sv
// cache_set_assoc: one N-way set-associative cache set.
// Handles read lookups and write/fill requests with a one-deep registered
// response stage, true-LRU replacement via per-way ages, and a bulk flush.
// Ages are a permutation of 0..WAYS-1: 0 is most recently used, WAYS-1 is LRU.

module cache_set_assoc #(
  parameter  int WAYS   = 4,
  parameter  int TAG_W  = 8,
  parameter  int DATA_W = 8,
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [WAY_W-1:0]  rsp_way,
  output logic [DATA_W-1:0] rsp_data
);

  // Per-way storage.
  logic              valid_q [WAYS];
  logic [TAG_W-1:0]  tag_q   [WAYS];
  logic [DATA_W-1:0] data_q  [WAYS];
  logic [WAY_W-1:0]  age_q   [WAYS];

  // Lookup / replacement decode.
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              has_free;
  logic [WAY_W-1:0]  free_way;
  logic [WAY_W-1:0]  lru_way;
  logic [WAY_W-1:0]  victim_way;
  logic [WAY_W-1:0]  touch_way;
  logic [WAY_W-1:0]  age_next [WAYS];
  logic              accept;
  logic              do_touch;

  // A request is taken only when no flush is pending and the response slot frees up.
  assign req_ready = !flush && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Tag match across ways; tags are unique within a set, so at most one matches.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise paths that skip the assignment infer a latch.
    hit     = 1'b0;
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
    end
  end

  // Victim selection: lowest-index invalid way, else the way whose age is WAYS-1.
  always_comb begin
    has_free = 1'b0;
    free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_way = WAY_W'(i);
      end
    end
    lru_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (age_q[i] == WAY_W'(WAYS - 1)) begin
        lru_way = WAY_W'(i);
      end
    end
    victim_way = has_free ? free_way : lru_way;
  end

  // LRU touch: ways younger than the touched way age by one; touched way becomes 0.
  always_comb begin
    touch_way = hit ? hit_way : victim_way;
    do_touch  = accept && (hit || req_write);
    for (int j = 0; j < WAYS; j++) begin
      if (age_q[j] < age_q[touch_way]) begin
        age_next[j] = age_q[j] + WAY_W'(1);
      end else begin
        age_next[j] = age_q[j];
      end
    end
    age_next[touch_way] = '0;
  end

  // Way storage, LRU state and flush.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      // NOTE: the storage arrays are reset explicitly because tags and data must
      // read as zero after reset; this keeps them in flops rather than RAM.
      for (int i = 0; i < WAYS; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
        age_q[i]   <= WAY_W'(i);
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (flush) begin
        for (int i = 0; i < WAYS; i++) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (accept && req_write) begin
        if (hit) begin
          data_q[hit_way] <= req_data;
        end else begin
          valid_q[victim_way] <= 1'b1;
          tag_q[victim_way]   <= req_tag;
          data_q[victim_way]  <= req_data;
        end
      end
      if (do_touch) begin
        for (int i = 0; i < WAYS; i++) begin
          age_q[i] <= age_next[i];
        end
      end
    end
  end

  // Registered response stage; held while the consumer stalls.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
      rsp_data  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_hit   <= hit;
      if (hit) begin
        rsp_way  <= hit_way;
        rsp_data <= req_write ? req_data : data_q[hit_way];
      end else if (req_write) begin
        rsp_way  <= victim_way;
        rsp_data <= req_data;
      end else begin
        rsp_way  <= '0;
        rsp_data <= '0;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_set_assoc.sv
// tb_cache_set_assoc: directed scenarios followed by randomized traffic,
// checked against a behavioural model that tracks recency as an ordered list.

module tb_cache_set_assoc;

  localparam int WAYS   = 4;
  localparam int TAG_W  = 8;
  localparam int DATA_W = 8;
  localparam int WAY_W  = $clog2(WAYS);

  logic              clock;
  logic              clear;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [WAY_W-1:0]  rsp_way;
  logic [DATA_W-1:0] rsp_data;

  cache_set_assoc #(.WAYS(WAYS), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .clear     (clear),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_way   (rsp_way),
    .rsp_data  (rsp_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: contents per way plus a recency list, most recent first.
  logic       m_valid [WAYS];
  logic [7:0] m_tag   [WAYS];
  logic [7:0] m_data  [WAYS];
  int         m_order [$];

  // Expected contents of the most recent response.
  logic       exp_hit;
  int         exp_way;
  logic [7:0] exp_data;
  logic       pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void touch(input int w);
    for (int k = 0; k < m_order.size(); k++) begin
      if (m_order[k] == w) begin
        m_order.delete(k);
        break;
      end
    end
    m_order.push_front(w);
  endfunction

  function automatic void model_reset();
    m_order.delete();
    for (int i = 0; i < WAYS; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 8'h00;
      m_data[i]  = 8'h00;
      m_order.push_back(i);
    end
    pend = 1'b0;
  endfunction

  // Entered and left at posedge+1.
  task automatic reset_dut();
    clear = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_hit",   32'(rsp_hit),   32'd0);
    check("rst_rsp_way",   32'(rsp_way),   32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    model_reset();
    #2;
    clear = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // One accepted request with rsp_ready high; checks the response one edge later.
  task automatic do_req(input logic wr, input logic [7:0] t, input logic [7:0] d);
    int w;
    w = -1;
    for (int i = 0; i < WAYS; i++) begin
      if (m_valid[i] && m_tag[i] == t) w = i;
    end
    if (w >= 0) begin
      exp_hit = 1'b1;
      exp_way = w;
      if (wr) m_data[w] = d;
      exp_data = m_data[w];
      touch(w);
    end else if (!wr) begin
      exp_hit  = 1'b0;
      exp_way  = 0;
      exp_data = 8'h00;
    end else begin
      for (int i = WAYS - 1; i >= 0; i--) begin
        if (!m_valid[i]) w = i;
      end
      if (w < 0) w = m_order[$];
      m_valid[w] = 1'b1;
      m_tag[w]   = t;
      m_data[w]  = d;
      exp_hit    = 1'b0;
      exp_way    = w;
      exp_data   = d;
      touch(w);
    end
    req_valid = 1'b1;
    req_write = wr;
    req_tag   = t;
    req_data  = d;
    rsp_ready = 1'b1;
    #1;
    check("req_ready", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    pend = 1'b1;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_hit",   32'(rsp_hit),   32'(exp_hit));
    check("rsp_way",   32'(rsp_way),   32'(exp_way));
    check("rsp_data",  32'(rsp_data),  32'(exp_data));
  endtask

  // Consumer stalls for n cycles while a request waits; nothing may change.
  task automatic stall(input int n);
    req_valid = 1'b1;
    req_write = 1'($urandom);
    req_tag   = 8'hD0 + 8'($urandom_range(0, 7));
    req_data  = 8'($urandom);
    rsp_ready = 1'b0;
    for (int c = 0; c < n; c++) begin
      #1;
      check("stall_req_ready", 32'(req_ready), 32'd0);
      @(posedge clock);
      #1;
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_hit",   32'(rsp_hit),   32'(exp_hit));
      check("stall_rsp_way",   32'(rsp_way),   32'(exp_way));
      check("stall_rsp_data",  32'(rsp_data),  32'(exp_data));
    end
    req_valid = 1'b0;
  endtask

  // Flush pulse with a competing request; hold keeps any pending response waiting.
  task automatic do_flush(input logic hold);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_tag   = 8'h5A;
    req_data  = 8'hEE;
    rsp_ready = !hold;
    #1;
    check("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clock);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < WAYS; i++) m_valid[i] = 1'b0;
    pend = pend && hold;
    check("flush_rsp_valid", 32'(rsp_valid), 32'(pend));
    if (pend) begin
      check("flush_rsp_hit",  32'(rsp_hit),  32'(exp_hit));
      check("flush_rsp_data", 32'(rsp_data), 32'(exp_data));
    end
  endtask

  initial begin
    clear     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_tag   = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    @(posedge clock);
    #1;
    reset_dut();

    // Read miss on an empty set.
    do_req(1'b0, 8'h12, 8'h00);

    // Fill all ways in order, then a read hit.
    for (int i = 0; i < 4; i++) do_req(1'b1, 8'hA0 + 8'(i), 8'h10 + 8'(i));
    do_req(1'b0, 8'hA2, 8'h00);

    // LRU victim after touching A0.
    do_req(1'b0, 8'hA0, 8'h00);
    do_req(1'b1, 8'hB0, 8'h55);
    check("lru_victim_way", 32'(rsp_way), 32'd1);
    do_req(1'b0, 8'hA1, 8'h00);
    do_req(1'b0, 8'hB0, 8'h00);

    // Backpressure for three cycles, then back-to-back accept.
    do_req(1'b0, 8'hB0, 8'h00);
    stall(3);
    do_req(1'b0, 8'hA3, 8'h00);
    do_req(1'b0, 8'hCC, 8'h00);

    // Flush while a request is offered and a response is pending.
    for (int i = 0; i < 4; i++) do_req(1'b1, 8'hC0 + 8'(i), 8'h60 + 8'(i));
    do_flush(1'b1);
    for (int i = 0; i < 4; i++) do_req(1'b0, 8'hC0 + 8'(i), 8'h00);
    do_req(1'b1, 8'hC7, 8'h77);
    check("flush_alloc_way0", 32'(rsp_way), 32'd0);

    // Asynchronous reset with a response pending.
    do_req(1'b1, 8'hE5, 8'h99);
    reset_dut();
    do_req(1'b0, 8'hE5, 8'h00);

    // Randomized traffic over a small tag pool.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0) begin
        do_flush(1'($urandom));
      end else if (r == 1 && pend) begin
        stall(int'($urandom_range(1, 3)));
      end else begin
        do_req(1'($urandom), 8'hD0 + 8'($urandom_range(0, 7)), 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
